bf2_bundle_stage: RTL and testbench



---
 rtl/bf2_bundle_stage.sv | 135 +++++++++++++
 tb/tb_bf2_bundle_stage.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf2_bundle_stage.sv
// bf2_bundle_stage: one radix-2 butterfly stage of the bundled-parallel FFT.
// Each beat carries LANES complex samples. Lane p is paired with lane p+STRIDE
// inside each group of 2*STRIDE lanes, producing a+b and a-b with one bit of
// growth (optionally halved with rounding). Results land in a 2-entry output
// buffer so the stage keeps full throughput under downstream backpressure.
module bf2_bundle_stage #(
  parameter int WIDTH  = 9,
  parameter int LANES  = 16,
  parameter int STRIDE = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic                           scale,
  input  logic [LANES*WIDTH-1:0]         din_R,
  input  logic [LANES*WIDTH-1:0]         din_Q,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [LANES*(WIDTH+1)-1:0]     dout_R,
  output logic [LANES*(WIDTH+1)-1:0]     dout_Q
);

  localparam int OW     = WIDTH + 1;
  localparam int VW     = LANES * OW;
  localparam int GROUPS = LANES / (2 * STRIDE);
  localparam logic signed [WIDTH+1:0] ONE = {{(WIDTH+1){1'b0}}, 1'b1};

  // Takes a WIDTH+2 sum/difference down to WIDTH+1 bits. Without halving the
  // top bit is a pure sign copy, so the truncation is exact; with halving we
  // add one and shift arithmetically, rounding ties toward +infinity.
  function automatic logic [OW-1:0] shapeResult(input logic signed [WIDTH+1:0] x,
                                                input logic halve);
    logic signed [WIDTH+1:0] rounded;
    rounded = (x + ONE) >>> 1;
    shapeResult = halve ? rounded[OW-1:0] : x[OW-1:0];
  endfunction

  logic [VW-1:0] calcR, calcQ;

  logic [VW-1:0] headR_q, headR_d, headQ_q, headQ_d;
  logic [VW-1:0] tailR_q, tailR_d, tailQ_q, tailQ_d;
  logic          headLast_q, headLast_d, tailLast_q, tailLast_d;
  logic [1:0]    count_q, count_d;
  logic          push, pop;

  // Butterfly array: one adder/subtractor pair per lane pair, I and Q apart.
  for (genvar g = 0; g < GROUPS; g++) begin : gGroup
    for (genvar i = 0; i < STRIDE; i++) begin : gPair
      localparam int P = g * 2 * STRIDE + i;
      localparam int Q = P + STRIDE;
      logic signed [WIDTH+1:0] aR, bR, aQ, bQ;
      assign aR = {{2{din_R[P*WIDTH+WIDTH-1]}}, din_R[P*WIDTH +: WIDTH]};
      assign bR = {{2{din_R[Q*WIDTH+WIDTH-1]}}, din_R[Q*WIDTH +: WIDTH]};
      assign aQ = {{2{din_Q[P*WIDTH+WIDTH-1]}}, din_Q[P*WIDTH +: WIDTH]};
      assign bQ = {{2{din_Q[Q*WIDTH+WIDTH-1]}}, din_Q[Q*WIDTH +: WIDTH]};
      assign calcR[P*OW +: OW] = shapeResult(aR + bR, scale);
      assign calcR[Q*OW +: OW] = shapeResult(aR - bR, scale);
      assign calcQ[P*OW +: OW] = shapeResult(aQ + bQ, scale);
      assign calcQ[Q*OW +: OW] = shapeResult(aQ - bQ, scale);
    end
  end

  // Handshake flags come only from the registered occupancy, so there is no
  // combinational path from out_ready back to in_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // The head slot is always what is presented. Popping the only entry leaves
  // the head untouched, which is how the outputs hold the last popped beat.
  assign dout_R   = headR_q;
  assign dout_Q   = headQ_q;
  assign out_last = headLast_q;

  // Buffer next state: push fills the first free slot, pop shifts the tail
  // forward, and push+pop (only possible at occupancy 1) replaces the head.
  always_comb begin
    count_d    = count_q;
    headR_d    = headR_q;
    headQ_d    = headQ_q;
    headLast_d = headLast_q;
    tailR_d    = tailR_q;
    tailQ_d    = tailQ_q;
    tailLast_d = tailLast_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
      if (count_q == 2'd0) begin
        headR_d    = calcR;
        headQ_d    = calcQ;
        headLast_d = in_last;
      end else begin
        tailR_d    = calcR;
        tailQ_d    = calcQ;
        tailLast_d = in_last;
      end
    end else if (!push && pop) begin
      count_d = count_q - 2'd1;
      if (count_q == 2'd2) begin
        headR_d    = tailR_q;
        headQ_d    = tailQ_q;
        headLast_d = tailLast_q;
      end
    end else if (push && pop) begin
      headR_d    = calcR;
      headQ_d    = calcQ;
      headLast_d = in_last;
    end
  end

  // Buffer registers; reset drops every buffered beat and clears the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      headR_q    <= '0;
      headQ_q    <= '0;
      headLast_q <= 1'b0;
      tailR_q    <= '0;
      tailQ_q    <= '0;
      tailLast_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      headR_q    <= headR_d;
      headQ_q    <= headQ_d;
      headLast_q <= headLast_d;
      tailR_q    <= tailR_d;
      tailQ_q    <= tailQ_d;
      tailLast_q <= tailLast_d;
    end
  end

endmodule

// File: tb/tb_bf2_bundle_stage.sv
// Testbench for bf2_bundle_stage: directed vectors, a table of all-lane
// extremes, backpressure/reset sequences, randomized streaming against a
// plain-arithmetic model, and a LANES=8/STRIDE=1 pairing check.
module tb_bf2_bundle_stage;

  localparam int WIDTH  = 9;
  localparam int LANES  = 16;
  localparam int STRIDE = 4;
  localparam int OW     = WIDTH + 1;
  localparam int IVW    = LANES * WIDTH;
  localparam int VW     = LANES * OW;
  localparam int L8     = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready, in_last, scale;
  logic [IVW-1:0] din_R, din_Q;
  logic           out_valid, out_ready, out_last;
  logic [VW-1:0]  dout_R, dout_Q;

  logic              v8, rdy8, last8, valid8, outLast8;
  logic [L8*WIDTH-1:0] din8R, din8Q;
  logic [L8*OW-1:0]    dout8R, dout8Q;
  logic              inReady8;

  bf2_bundle_stage #(.WIDTH(WIDTH), .LANES(LANES), .STRIDE(STRIDE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .scale(scale),
    .din_R(din_R), .din_Q(din_Q),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .dout_R(dout_R), .dout_Q(dout_Q)
  );

  bf2_bundle_stage #(.WIDTH(WIDTH), .LANES(L8), .STRIDE(1)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(inReady8), .in_last(last8), .scale(1'b0),
    .din_R(din8R), .din_Q(din8Q),
    .out_valid(valid8), .out_ready(rdy8), .out_last(outLast8),
    .dout_R(dout8R), .dout_Q(dout8Q)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic [VW-1:0] r;
    logic [VW-1:0] q;
    logic          last;
  } beat_t;

  beat_t sb[$];

  typedef struct {
    int aR, bR, aQ, bQ;
    bit sc;
    int pR, qR, pQ, qQ;
  } vec_t;

  vec_t vecs[6];
  int   laneR[LANES], laneQ[LANES], expR[LANES], expQ[LANES];

  // Reference model helpers: plain integer arithmetic per lane.
  function automatic int laneVal(input logic [IVW-1:0] v, input int idx);
    logic signed [WIDTH-1:0] t;
    t = v[idx*WIDTH +: WIDTH];
    return int'(t);
  endfunction

  function automatic int floorHalf(input int v);
    if (v >= 0) return v / 2;
    return -((-v + 1) / 2);
  endfunction

  function automatic logic [VW-1:0] model(input logic [IVW-1:0] din, input bit sc);
    logic [VW-1:0] res;
    res = '0;
    for (int p = 0; p < LANES; p++) begin
      int off, y;
      off = p % (2 * STRIDE);
      if (off < STRIDE) y = laneVal(din, p) + laneVal(din, p + STRIDE);
      else              y = laneVal(din, p - STRIDE) - laneVal(din, p);
      if (sc) y = floorHalf(y + 1);
      res[p*OW +: OW] = y[OW-1:0];
    end
    return res;
  endfunction

  function automatic logic [IVW-1:0] packIn(input int v[LANES]);
    logic [IVW-1:0] res;
    for (int p = 0; p < LANES; p++) res[p*WIDTH +: WIDTH] = v[p][WIDTH-1:0];
    return res;
  endfunction

  function automatic logic [VW-1:0] packOut(input int v[LANES]);
    logic [VW-1:0] res;
    for (int p = 0; p < LANES; p++) res[p*OW +: OW] = v[p][OW-1:0];
    return res;
  endfunction

  function automatic logic [IVW-1:0] randVec();
    logic [IVW-1:0] res;
    for (int p = 0; p < LANES; p++) begin
      logic [31:0] r;
      r = $urandom;
      res[p*WIDTH +: WIDTH] = r[WIDTH-1:0];
    end
    return res;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [IVW-1:0] r, input logic [IVW-1:0] q,
                               input logic sc, input logic last, input logic valid);
    din_R    = r;
    din_Q    = q;
    scale    = sc;
    in_last  = last;
    in_valid = valid;
  endtask

  task automatic checkOutput(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic checkFlag(input string nm, input logic act, input logic exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  // Randomized streaming: random valid/ready, scoreboard of model beats.
  task automatic runStream(input int nBeats, input bit randScale);
    int             sent, cycles;
    logic [IVW-1:0] nR, nQ;
    bit             nSc, doPush, doPop;
    beat_t          h;
    sent   = 0;
    cycles = 0;
    nR     = randVec();
    nQ     = randVec();
    nSc    = randScale ? bit'($urandom_range(0, 1)) : 1'b0;
    while ((sent < nBeats || sb.size() != 0) && cycles < 2000) begin
      applyStimulus(nR, nQ, nSc, (sent % 8) == 7,
                    (sent < nBeats) && ($urandom_range(0, 3) != 0));
      out_ready = ($urandom_range(0, 1) == 1);
      checkFlag("stream in_ready", in_ready, sb.size() != 2);
      checkFlag("stream out_valid", out_valid, sb.size() != 0);
      doPush = in_valid && (sb.size() != 2);
      doPop  = out_ready && (sb.size() != 0);
      if (doPop) begin
        h = sb.pop_front();
        checkOutput("stream dout_R", dout_R, h.r);
        checkOutput("stream dout_Q", dout_Q, h.q);
        checkFlag("stream out_last", out_last, h.last);
      end
      if (doPush) sb.push_back('{r: model(nR, nSc), q: model(nQ, nSc), last: in_last});
      step();
      if (doPush) begin
        sent++;
        nR  = randVec();
        nQ  = randVec();
        nSc = randScale ? bit'($urandom_range(0, 1)) : 1'b0;
      end
      cycles++;
    end
    testsRun++;
    if (cycles >= 2000) begin
      testsFailed++;
      $display("[TB] FAIL stream timeout: got %0d beats sent, expected %0d", sent, nBeats);
      sb.delete();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    logic [IVW-1:0] b1R, b1Q, b2R, b2Q, b3R, b3Q;
    logic [L8*OW-1:0] exp8R, exp8Q;

    vecs[0] = '{aR: 255,  bR: 255,  aQ: -256, bQ: 255, sc: 0, pR: 510,  qR: 0,    pQ: -1,   qQ: -511};
    vecs[1] = '{aR: -256, bR: 255,  aQ: 255,  bQ: 255, sc: 0, pR: -1,   qR: -511, pQ: 510,  qQ: 0};
    vecs[2] = '{aR: 3,    bR: 0,    aQ: -3,   bQ: 0,   sc: 1, pR: 2,    qR: 2,    pQ: -1,   qQ: -1};
    vecs[3] = '{aR: -256, bR: -256, aQ: 3,    bQ: 0,   sc: 1, pR: -256, qR: 0,    pQ: 2,    qQ: 2};
    vecs[4] = '{aR: -256, bR: -256, aQ: -256, bQ: -256, sc: 0, pR: -512, qR: 0,   pQ: -512, qQ: 0};
    vecs[5] = '{aR: 255,  bR: -256, aQ: 1,    bQ: 0,   sc: 1, pR: 0,    qR: 256,  pQ: 1,    qQ: 1};

    rst_n = 1'b0;
    applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    v8 = 1'b0; rdy8 = 1'b1; last8 = 1'b0; din8R = '0; din8Q = '0;
    #12;
    checkFlag("reset out_valid", out_valid, 1'b0);
    checkFlag("reset in_ready", in_ready, 1'b1);
    checkFlag("reset out_last", out_last, 1'b0);
    checkOutput("reset dout_R", dout_R, '0);
    checkOutput("reset dout_Q", dout_Q, '0);
    rst_n = 1'b1;
    step();

    // Basic butterfly, one beat, out_ready high.
    laneR = '{default: 0}; laneQ = '{default: 0};
    expR  = '{default: 0}; expQ  = '{default: 0};
    laneR[0] = 100; laneR[4] = 50; laneQ[8] = -3; laneQ[12] = 7;
    expR[0] = 150;  expR[4] = 50;  expQ[8] = 4;   expQ[12] = -10;
    out_ready = 1'b1;
    applyStimulus(packIn(laneR), packIn(laneQ), 1'b0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    checkFlag("basic out_valid", out_valid, 1'b1);
    checkOutput("basic dout_R", dout_R, packOut(expR));
    checkOutput("basic dout_Q", dout_Q, packOut(expQ));
    step();
    checkFlag("basic single beat", out_valid, 1'b0);

    // Table of all-lane extremes and scaling cases, streamed back to back.
    for (int k = 0; k < 6; k++) begin
      for (int p = 0; p < LANES; p++) begin
        bit first;
        first    = (p % (2 * STRIDE)) < STRIDE;
        laneR[p] = first ? vecs[k].aR : vecs[k].bR;
        laneQ[p] = first ? vecs[k].aQ : vecs[k].bQ;
        expR[p]  = first ? vecs[k].pR : vecs[k].qR;
        expQ[p]  = first ? vecs[k].pQ : vecs[k].qQ;
      end
      applyStimulus(packIn(laneR), packIn(laneQ), vecs[k].sc, 1'b0, 1'b1);
      step();
      checkOutput($sformatf("table %0d dout_R", k), dout_R, packOut(expR));
      checkOutput($sformatf("table %0d dout_Q", k), dout_Q, packOut(expQ));
    end
    in_valid = 1'b0;
    step();
    checkFlag("table drained", out_valid, 1'b0);

    // Backpressure: three beats offered with out_ready low.
    b1R = randVec(); b1Q = randVec();
    b2R = randVec(); b2Q = randVec();
    b3R = randVec(); b3Q = randVec();
    out_ready = 1'b0;
    applyStimulus(b1R, b1Q, 1'b0, 1'b0, 1'b1);
    step();
    checkFlag("bp in_ready after 1", in_ready, 1'b1);
    applyStimulus(b2R, b2Q, 1'b1, 1'b1, 1'b1);
    step();
    checkFlag("bp in_ready after 2", in_ready, 1'b0);
    applyStimulus(b3R, b3Q, 1'b0, 1'b0, 1'b1);
    step();
    step();
    checkFlag("bp held in_ready", in_ready, 1'b0);
    checkFlag("bp held out_valid", out_valid, 1'b1);
    checkOutput("bp held dout_R", dout_R, model(b1R, 1'b0));
    checkFlag("bp held out_last", out_last, 1'b0);
    out_ready = 1'b1;
    step();
    checkFlag("bp in_ready after pop", in_ready, 1'b1);
    checkOutput("bp beat2 dout_R", dout_R, model(b2R, 1'b1));
    checkOutput("bp beat2 dout_Q", dout_Q, model(b2Q, 1'b1));
    checkFlag("bp beat2 out_last", out_last, 1'b1);
    step();
    in_valid = 1'b0;
    checkFlag("bp beat3 out_valid", out_valid, 1'b1);
    checkOutput("bp beat3 dout_R", dout_R, model(b3R, 1'b0));
    checkFlag("bp beat3 out_last", out_last, 1'b0);
    step();
    checkFlag("bp drained", out_valid, 1'b0);
    checkOutput("bp hold last popped", dout_Q, model(b3Q, 1'b0));

    // Streaming frames with random backpressure.
    runStream(8, 1'b0);
    runStream(64, 1'b1);

    // Reset with two beats buffered.
    out_ready = 1'b0;
    applyStimulus(randVec(), randVec(), 1'b0, 1'b1, 1'b1);
    step();
    applyStimulus(randVec(), randVec(), 1'b0, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    checkFlag("pre-reset in_ready", in_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkFlag("midreset out_valid", out_valid, 1'b0);
    checkFlag("midreset in_ready", in_ready, 1'b1);
    checkFlag("midreset out_last", out_last, 1'b0);
    checkOutput("midreset dout_R", dout_R, '0);
    checkOutput("midreset dout_Q", dout_Q, '0);
    #3 rst_n = 1'b1;
    step();
    b1R = randVec(); b1Q = randVec();
    applyStimulus(b1R, b1Q, 1'b1, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    checkFlag("post-reset out_valid", out_valid, 1'b1);
    checkOutput("post-reset dout_R", dout_R, model(b1R, 1'b1));
    checkOutput("post-reset dout_Q", dout_Q, model(b1Q, 1'b1));
    out_ready = 1'b1;
    step();
    checkFlag("post-reset drained", out_valid, 1'b0);

    // LANES=8, STRIDE=1 pairing: (0,1) on R and (4,5) on Q.
    din8R = '0; din8Q = '0;
    din8R[0*WIDTH +: WIDTH] = 9'd100;
    din8R[1*WIDTH +: WIDTH] = 9'd50;
    din8Q[4*WIDTH +: WIDTH] = 9'h1FD;
    din8Q[5*WIDTH +: WIDTH] = 9'd7;
    exp8R = '0; exp8Q = '0;
    exp8R[0*OW +: OW] = 10'd150;
    exp8R[1*OW +: OW] = 10'd50;
    exp8Q[4*OW +: OW] = 10'd4;
    exp8Q[5*OW +: OW] = 10'h3F6;
    v8 = 1'b1;
    step();
    v8 = 1'b0;
    checkFlag("lanes8 out_valid", valid8, 1'b1);
    testsRun++;
    if (dout8R !== exp8R || dout8Q !== exp8Q) begin
      testsFailed++;
      $display("[TB] FAIL lanes8 dout: got %h/%h, expected %h/%h", dout8R, dout8Q, exp8R, exp8Q);
    end
    step();
    checkFlag("lanes8 single beat", valid8, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
